// File: rtl/alu_rs_pkg.sv
// Shared constants for the ALU reservation station slice.
// Default widths and the RV32I opcodes the ALU path accepts.
package alu_rs_pkg;

  localparam int DEF_ROB_BIT = 4;
  localparam int DEF_RS_SIZE = 8;
  localparam int DEF_RS_BIT  = 3;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-set-bit priority encoder used for slot selection.
// idx is the lowest asserted bit of vec; found flags any bit set.
module rs_prio_enc #(
  parameter int RS_SIZE = 8,
  parameter int RS_BIT  = 3
) (
  input  logic [RS_SIZE-1:0] vec,
  output logic [RS_BIT-1:0]  idx,
  output logic               found
);

  always_comb begin
    idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (vec[i]) idx = RS_BIT'(i);
    end
  end

  assign found = |vec;

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds issued ops until both operands
// resolve from the CDBs, then dispatches the lowest ready entry.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = DEF_RS_SIZE,
  parameter int RS_BIT  = DEF_RS_BIT,
  parameter int ROB_BIT = DEF_ROB_BIT
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               flush_in,
  input  logic               iss_valid,
  input  logic [2:0]         iss_op,
  input  logic [6:0]         iss_op_type,
  input  logic               iss_op_addition,
  input  logic [ROB_BIT-1:0] iss_rob_entry,
  input  logic               iss_qi_busy,
  input  logic [ROB_BIT-1:0] iss_qi,
  input  logic [31:0]        iss_vi,
  input  logic               iss_qj_busy,
  input  logic [ROB_BIT-1:0] iss_qj,
  input  logic [31:0]        iss_vj,
  input  logic               cdb0_valid,
  input  logic [ROB_BIT-1:0] cdb0_rob,
  input  logic [31:0]        cdb0_val,
  input  logic               cdb1_valid,
  input  logic [ROB_BIT-1:0] cdb1_rob,
  input  logic [31:0]        cdb1_val,
  output logic               rs_full,
  output logic               alu_valid,
  output logic [31:0]        alu_vi,
  output logic [31:0]        alu_vj,
  output logic [2:0]         alu_op,
  output logic [6:0]         alu_op_type,
  output logic               alu_op_addition,
  output logic [ROB_BIT-1:0] alu_rob_entry
);

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] qi_busy;
  logic [RS_SIZE-1:0] qj_busy;
  logic [ROB_BIT-1:0] qi   [RS_SIZE];
  logic [ROB_BIT-1:0] qj   [RS_SIZE];
  logic [31:0]        vi   [RS_SIZE];
  logic [31:0]        vj   [RS_SIZE];
  logic [2:0]         op   [RS_SIZE];
  logic [6:0]         opt  [RS_SIZE];
  logic               oadd [RS_SIZE];
  logic [ROB_BIT-1:0] rob  [RS_SIZE];

  logic [RS_SIZE-1:0] free_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic [RS_BIT-1:0]  free_idx;
  logic [RS_BIT-1:0]  rdy_idx;
  logic               free_found;
  logic               rdy_found;

  logic               ins_qi_busy;
  logic               ins_qj_busy;
  logic [31:0]        ins_vi;
  logic [31:0]        ins_vj;

  assign free_vec  = ~busy;
  assign ready_vec = busy & ~qi_busy & ~qj_busy;
  assign rs_full   = &busy;

  rs_prio_enc #(.RS_SIZE(RS_SIZE), .RS_BIT(RS_BIT)) u_free (
    .vec   (free_vec),
    .idx   (free_idx),
    .found (free_found)
  );

  rs_prio_enc #(.RS_SIZE(RS_SIZE), .RS_BIT(RS_BIT)) u_ready (
    .vec   (ready_vec),
    .idx   (rdy_idx),
    .found (rdy_found)
  );

  // Operands broadcast in the issue cycle are captured on insert.
  always_comb begin
    ins_qi_busy = iss_qi_busy;
    ins_vi      = iss_vi;
    if (iss_qi_busy && cdb0_valid && iss_qi == cdb0_rob) begin
      ins_qi_busy = 1'b0;
      ins_vi      = cdb0_val;
    end else if (iss_qi_busy && cdb1_valid && iss_qi == cdb1_rob) begin
      ins_qi_busy = 1'b0;
      ins_vi      = cdb1_val;
    end
    ins_qj_busy = iss_qj_busy;
    ins_vj      = iss_vj;
    if (iss_qj_busy && cdb0_valid && iss_qj == cdb0_rob) begin
      ins_qj_busy = 1'b0;
      ins_vj      = cdb0_val;
    end else if (iss_qj_busy && cdb1_valid && iss_qj == cdb1_rob) begin
      ins_qj_busy = 1'b0;
      ins_vj      = cdb1_val;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy            <= '0;
      qi_busy         <= '0;
      qj_busy         <= '0;
      alu_valid       <= 1'b0;
      alu_vi          <= '0;
      alu_vj          <= '0;
      alu_op          <= '0;
      alu_op_type     <= '0;
      alu_op_addition <= 1'b0;
      alu_rob_entry   <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        qi[i]   <= '0;
        qj[i]   <= '0;
        vi[i]   <= '0;
        vj[i]   <= '0;
        op[i]   <= '0;
        opt[i]  <= '0;
        oadd[i] <= 1'b0;
        rob[i]  <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        busy      <= '0;
        alu_valid <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i] && qi_busy[i]) begin
            if (cdb0_valid && qi[i] == cdb0_rob) begin
              vi[i]      <= cdb0_val;
              qi_busy[i] <= 1'b0;
            end else if (cdb1_valid && qi[i] == cdb1_rob) begin
              vi[i]      <= cdb1_val;
              qi_busy[i] <= 1'b0;
            end
          end
          if (busy[i] && qj_busy[i]) begin
            if (cdb0_valid && qj[i] == cdb0_rob) begin
              vj[i]      <= cdb0_val;
              qj_busy[i] <= 1'b0;
            end else if (cdb1_valid && qj[i] == cdb1_rob) begin
              vj[i]      <= cdb1_val;
              qj_busy[i] <= 1'b0;
            end
          end
        end
        alu_valid <= rdy_found;
        if (rdy_found) begin
          alu_vi          <= vi[rdy_idx];
          alu_vj          <= vj[rdy_idx];
          alu_op          <= op[rdy_idx];
          alu_op_type     <= opt[rdy_idx];
          alu_op_addition <= oadd[rdy_idx];
          alu_rob_entry   <= rob[rdy_idx];
          busy[rdy_idx]   <= 1'b0;
        end
        // A free slot is never the ready slot, so both writes coexist.
        if (iss_valid && !rs_full && free_found) begin
          busy[free_idx]    <= 1'b1;
          op[free_idx]      <= iss_op;
          opt[free_idx]     <= iss_op_type;
          oadd[free_idx]    <= iss_op_addition;
          rob[free_idx]     <= iss_rob_entry;
          qi_busy[free_idx] <= ins_qi_busy;
          qi[free_idx]      <= iss_qi;
          vi[free_idx]      <= ins_vi;
          qj_busy[free_idx] <= ins_qj_busy;
          qj[free_idx]      <= iss_qj;
          vj[free_idx]      <= ins_vj;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed testbench for alu_rs: insert, wakeup, bypass, full,
// flush, stall and reset scenarios with hand-computed results.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic        iss_valid;
  logic [2:0]  iss_op;
  logic [6:0]  iss_op_type;
  logic        iss_op_addition;
  logic [3:0]  iss_rob_entry;
  logic        iss_qi_busy;
  logic [3:0]  iss_qi;
  logic [31:0] iss_vi;
  logic        iss_qj_busy;
  logic [3:0]  iss_qj;
  logic [31:0] iss_vj;
  logic        cdb0_valid;
  logic [3:0]  cdb0_rob;
  logic [31:0] cdb0_val;
  logic        cdb1_valid;
  logic [3:0]  cdb1_rob;
  logic [31:0] cdb1_val;
  logic        rs_full;
  logic        alu_valid;
  logic [31:0] alu_vi;
  logic [31:0] alu_vj;
  logic [2:0]  alu_op;
  logic [6:0]  alu_op_type;
  logic        alu_op_addition;
  logic [3:0]  alu_rob_entry;

  int n_cmp = 0;
  int n_err = 0;

  alu_rs dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .flush_in        (flush_in),
    .iss_valid       (iss_valid),
    .iss_op          (iss_op),
    .iss_op_type     (iss_op_type),
    .iss_op_addition (iss_op_addition),
    .iss_rob_entry   (iss_rob_entry),
    .iss_qi_busy     (iss_qi_busy),
    .iss_qi          (iss_qi),
    .iss_vi          (iss_vi),
    .iss_qj_busy     (iss_qj_busy),
    .iss_qj          (iss_qj),
    .iss_vj          (iss_vj),
    .cdb0_valid      (cdb0_valid),
    .cdb0_rob        (cdb0_rob),
    .cdb0_val        (cdb0_val),
    .cdb1_valid      (cdb1_valid),
    .cdb1_rob        (cdb1_rob),
    .cdb1_val        (cdb1_val),
    .rs_full         (rs_full),
    .alu_valid       (alu_valid),
    .alu_vi          (alu_vi),
    .alu_vj          (alu_vj),
    .alu_op          (alu_op),
    .alu_op_type     (alu_op_type),
    .alu_op_addition (alu_op_addition),
    .alu_rob_entry   (alu_rob_entry)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    iss_valid = 0; iss_op = 0; iss_op_type = 0; iss_op_addition = 0;
    iss_rob_entry = 0; iss_qi_busy = 0; iss_qi = 0; iss_vi = 0;
    iss_qj_busy = 0; iss_qj = 0; iss_vj = 0;
    cdb0_valid = 0; cdb0_rob = 0; cdb0_val = 0;
    cdb1_valid = 0; cdb1_rob = 0; cdb1_val = 0;
    flush_in = 0;
  endtask

  task automatic iss(input logic [3:0] rob, input logic qib,
                     input logic [3:0] qi, input logic [31:0] vi,
                     input logic qjb, input logic [3:0] qj,
                     input logic [31:0] vj, input logic [2:0] op,
                     input logic add);
    iss_valid = 1; iss_rob_entry = rob;
    iss_qi_busy = qib; iss_qi = qi; iss_vi = vi;
    iss_qj_busy = qjb; iss_qj = qj; iss_vj = vj;
    iss_op = op; iss_op_type = OPC_OP; iss_op_addition = add;
  endtask

  task automatic test_reset();
    idle();
    rdy_in = 1;
    rst_in = 0;
    #12;
    n_cmp++; if (alu_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b want 0", alu_valid); end
    n_cmp++; if (alu_vi !== 32'h0) begin n_err++; $display("FAIL rst_vi got %h want 0", alu_vi); end
    n_cmp++; if (alu_rob_entry !== 4'h0) begin n_err++; $display("FAIL rst_rob got %h want 0", alu_rob_entry); end
    n_cmp++; if (rs_full !== 1'b0) begin n_err++; $display("FAIL rst_full got %0b want 0", rs_full); end
    rst_in = 1;
    tick();
    n_cmp++; if (alu_valid !== 1'b0) begin n_err++; $display("FAIL rst_idle got %0b want 0", alu_valid); end
  endtask

  task automatic test_basic();
    iss(4'd3, 0, 4'd0, 32'd5, 0, 4'd0, 32'd7, 3'b000, 0);
    tick();
    idle();
    n_cmp++; if (alu_valid !== 1'b0) begin n_err++; $display("FAIL basic_early got %0b want 0", alu_valid); end
    tick();
    n_cmp++; if (alu_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %0b want 1", alu_valid); end
    n_cmp++; if (alu_vi !== 32'd5) begin n_err++; $display("FAIL basic_vi got %h want 5", alu_vi); end
    n_cmp++; if (alu_vj !== 32'd7) begin n_err++; $display("FAIL basic_vj got %h want 7", alu_vj); end
    n_cmp++; if (alu_rob_entry !== 4'd3) begin n_err++; $display("FAIL basic_rob got %h want 3", alu_rob_entry); end
    n_cmp++; if (alu_op !== 3'b000) begin n_err++; $display("FAIL basic_op got %b want 000", alu_op); end
    n_cmp++; if (alu_op_addition !== 1'b0) begin n_err++; $display("FAIL basic_add got %b want 0", alu_op_addition); end
    n_cmp++; if (alu_op_type !== 7'b0110011) begin n_err++; $display("FAIL basic_type got %b want 0110011", alu_op_type); end
    tick();
    n_cmp++; if (alu_valid !== 1'b0) begin n_err++; $display("FAIL basic_pulse got %0b want 0", alu_valid); end
    n_cmp++; if (alu_vi !== 32'd5) begin n_err++; $display("FAIL basic_hold got %h want 5", alu_vi); end
  endtask

  task automatic test_wakeup();
    iss(4'd2, 1, 4'd6, 32'd0, 0, 4'd0, 32'd1, 3'b001, 0);
    tick();
    idle();
    tick();
    n_cmp++; if (alu_valid !== 1'b0) begin n_err++; $display("FAIL wake_wait got %0b want 0", alu_valid); end
    cdb1_valid = 1; cdb1_rob = 4'd6; cdb1_val = 32'h100;
    tick();
    idle();
    n_cmp++; if (alu_valid !== 1'b0) begin n_err++; $display("FAIL wake_latency got %0b want 0", alu_valid); end
    tick();
    n_cmp++; if (alu_valid !== 1'b1) begin n_err++; $display("FAIL wake_valid got %0b want 1", alu_valid); end
    n_cmp++; if (alu_vi !== 32'h100) begin n_err++; $display("FAIL wake_vi got %h want 100", alu_vi); end
    n_cmp++; if (alu_vj !== 32'd1) begin n_err++; $display("FAIL wake_vj got %h want 1", alu_vj); end
    n_cmp++; if (alu_rob_entry !== 4'd2) begin n_err++; $display("FAIL wake_rob got %h want 2", alu_rob_entry); end
    tick();
    n_cmp++; if (alu_valid !== 1'b0) begin n_err++; $display("FAIL wake_pulse got %0b want 0", alu_valid); end
  endtask

  task automatic test_bypass();
    iss(4'd5, 0, 4'd0, 32'd3, 1, 4'd4, 32'd0, 3'b000, 1);
    cdb0_valid = 1; cdb0_rob = 4'd4; cdb0_val = 32'd9;
    tick();
    idle();
    tick();
    n_cmp++; if (alu_valid !== 1'b1) begin n_err++; $display("FAIL byp_valid got %0b want 1", alu_valid); end
    n_cmp++; if (alu_vj !== 32'd9) begin n_err++; $display("FAIL byp_vj got %h want 9", alu_vj); end
    n_cmp++; if (alu_vi !== 32'd3) begin n_err++; $display("FAIL byp_vi got %h want 3", alu_vi); end
    n_cmp++; if (alu_rob_entry !== 4'd5) begin n_err++; $display("FAIL byp_rob got %h want 5", alu_rob_entry); end
    n_cmp++; if (alu_op_addition !== 1'b1) begin n_err++; $display("FAIL byp_add got %b want 1", alu_op_addition); end
    tick();
  endtask

  task automatic test_full();
    for (int k = 0; k < 8; k++) begin
      iss(4'(k), 1, 4'(8 + k), 32'd0, 0, 4'd0, 32'(k), 3'b000, 0);
      tick();
    end
    idle();
    n_cmp++; if (rs_full !== 1'b1) begin n_err++; $display("FAIL full_set got %0b want 1", rs_full); end
    n_cmp++; if (alu_valid !== 1'b0) begin n_err++; $display("FAIL full_nodisp got %0b want 0", alu_valid); end
    iss(4'd9, 0, 4'd0, 32'hDEAD, 0, 4'd0, 32'hBEEF, 3'b000, 0);
    tick();
    idle();
    n_cmp++; if (rs_full !== 1'b1) begin n_err++; $display("FAIL full_ign got %0b want 1", rs_full); end
    tick();
    n_cmp++; if (alu_valid !== 1'b0) begin n_err++; $display("FAIL full_9th got %0b want 0", alu_valid); end
    cdb0_valid = 1; cdb0_rob = 4'd13; cdb0_val = 32'h55;
    tick();
    idle();
    n_cmp++; if (alu_valid !== 1'b0) begin n_err++; $display("FAIL full_lat got %0b want 0", alu_valid); end
    tick();
    n_cmp++; if (alu_valid !== 1'b1) begin n_err++; $display("FAIL full_valid got %0b want 1", alu_valid); end
    n_cmp++; if (alu_rob_entry !== 4'd5) begin n_err++; $display("FAIL full_rob got %h want 5", alu_rob_entry); end
    n_cmp++; if (alu_vi !== 32'h55) begin n_err++; $display("FAIL full_vi got %h want 55", alu_vi); end
    n_cmp++; if (alu_vj !== 32'd5) begin n_err++; $display("FAIL full_vj got %h want 5", alu_vj); end
    n_cmp++; if (rs_full !== 1'b0) begin n_err++; $display("FAIL full_clr got %0b want 0", rs_full); end
    tick();
    n_cmp++; if (alu_valid !== 1'b0) begin n_err++; $display("FAIL full_once got %0b want 0", alu_valid); end
  endtask

  task automatic test_flush();
    logic [3:0] tags [5];
    tags[0] = 4'd10; tags[1] = 4'd7; tags[2] = 4'd11;
    tags[3] = 4'd12; tags[4] = 4'd7;
    flush_in = 1;
    tick();
    idle();
    n_cmp++; if (rs_full !== 1'b0) begin n_err++; $display("FAIL flush_pre got %0b want 0", rs_full); end
    for (int k = 0; k < 5; k++) begin
      iss(4'(k), 1, tags[k], 32'd0, 0, 4'd0, 32'd0, 3'b000, 0);
      tick();
    end
    idle();
    cdb0_valid = 1; cdb0_rob = 4'd7; cdb0_val = 32'hAA;
    tick();
    idle();
    flush_in = 1;
    tick();
    idle();
    n_cmp++; if (alu_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %0b want 0", alu_valid); end
    n_cmp++; if (rs_full !== 1'b0) begin n_err++; $display("FAIL flush_full got %0b want 0", rs_full); end
    cdb1_valid = 1; cdb1_rob = 4'd10; cdb1_val = 32'h1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (alu_valid !== 1'b0) begin n_err++; $display("FAIL flush_gone%0d got %0b want 0", k, alu_valid); end
    end
    idle();
  endtask

  task automatic test_stall();
    int seen;
    seen = 0;
    iss(4'd9, 0, 4'd0, 32'h11, 0, 4'd0, 32'h22, 3'b111, 0);
    tick();
    idle();
    rdy_in = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (alu_valid !== 1'b0) begin n_err++; $display("FAIL stall_hold%0d got %0b want 0", k, alu_valid); end
    end
    rdy_in = 1;
    tick();
    if (alu_valid && rdy_in) seen++;
    n_cmp++; if (alu_vi !== 32'h11) begin n_err++; $display("FAIL stall_vi got %h want 11", alu_vi); end
    n_cmp++; if (alu_op !== 3'b111) begin n_err++; $display("FAIL stall_op got %b want 111", alu_op); end
    rdy_in = 0;
    tick();
    n_cmp++; if (alu_valid !== 1'b1) begin n_err++; $display("FAIL stall_freeze got %0b want 1", alu_valid); end
    n_cmp++; if (alu_vj !== 32'h22) begin n_err++; $display("FAIL stall_vj got %h want 22", alu_vj); end
    rdy_in = 1;
    tick();
    if (alu_valid && rdy_in) seen++;
    tick();
    if (alu_valid && rdy_in) seen++;
    n_cmp++; if (seen !== 1) begin n_err++; $display("FAIL stall_count got %0d want 1", seen); end
  endtask

  task automatic test_reset_mid();
    iss(4'd6, 0, 4'd0, 32'h77, 0, 4'd0, 32'h1, 3'b010, 0);
    tick();
    iss(4'd7, 0, 4'd0, 32'h88, 0, 4'd0, 32'h2, 3'b011, 0);
    tick();
    idle();
    n_cmp++; if (alu_rob_entry !== 4'd6) begin n_err++; $display("FAIL rmid_pre got %h want 6", alu_rob_entry); end
    rst_in = 0;
    #1;
    n_cmp++; if (alu_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %0b want 0", alu_valid); end
    n_cmp++; if (alu_vi !== 32'h0) begin n_err++; $display("FAIL rmid_vi got %h want 0", alu_vi); end
    n_cmp++; if (alu_vj !== 32'h0) begin n_err++; $display("FAIL rmid_vj got %h want 0", alu_vj); end
    n_cmp++; if (alu_op !== 3'h0) begin n_err++; $display("FAIL rmid_op got %h want 0", alu_op); end
    n_cmp++; if (alu_op_type !== 7'h0) begin n_err++; $display("FAIL rmid_type got %h want 0", alu_op_type); end
    n_cmp++; if (alu_rob_entry !== 4'h0) begin n_err++; $display("FAIL rmid_rob got %h want 0", alu_rob_entry); end
    #1;
    rst_in = 1;
    tick();
    n_cmp++; if (alu_valid !== 1'b0) begin n_err++; $display("FAIL rmid_post got %0b want 0", alu_valid); end
    n_cmp++; if (rs_full !== 1'b0) begin n_err++; $display("FAIL rmid_full got %0b want 0", rs_full); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_full();
    test_flush();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
